// File: rtl/pool_window_ctrl_if.sv
// Pooled-pixel output stream: show-ahead FIFO head plus valid/ready handshake.
// The master drives pixels; the slave drives i_ready.
interface pool_window_ctrl_if #(
   parameter int unsigned OUT_WIDTH = 8
);
   logic [OUT_WIDTH-1:0] o_data;
   logic                 o_valid;
   logic                 o_last;
   logic                 i_ready;

   modport master (output o_data, output o_valid, output o_last, input i_ready);
   modport slave  (input o_data, input o_valid, input o_last, output i_ready);
endinterface

// File: rtl/pool_window_ctrl.sv
// Maxpool window sequencer: counts conv beats into windows, drives the maxpool, then
// requantises each window maximum and queues it in a small show-ahead output FIFO.
module pool_window_ctrl #(
   parameter int unsigned IN_WIDTH   = 48,
   parameter int unsigned OUT_WIDTH  = 8,
   parameter int unsigned POOL_SIZE  = 2,
   parameter int unsigned FM_SIZE    = 24,
   parameter int unsigned SHIFT      = 8,
   parameter int unsigned FIFO_DEPTH = 4
) (
   input  logic                       i_clk,
   input  logic                       i_rst,
   input  logic                       i_valid,
   input  logic signed [IN_WIDTH-1:0] i_mp_data,
   output logic                       o_clean,
   output logic                       o_en_mp,
   pool_window_ctrl_if.master         pix,
   output logic                       o_overflow,
   output logic                       o_gap_err
);

   localparam int unsigned WIN  = POOL_SIZE * POOL_SIZE;
   localparam int unsigned NWIN = (FM_SIZE / POOL_SIZE) * (FM_SIZE / POOL_SIZE);
   localparam int unsigned BW   = (WIN > 1) ? $clog2(WIN) : 1;
   localparam int unsigned WW   = (NWIN > 1) ? $clog2(NWIN) : 1;
   localparam int unsigned AW   = $clog2(FIFO_DEPTH);

   localparam logic [IN_WIDTH:0] Rnd    = (IN_WIDTH+1)'(1) << (SHIFT - 1);
   localparam logic [IN_WIDTH:0] SatMax = (IN_WIDTH+1)'((2 ** (OUT_WIDTH - 1)) - 1);

   logic [BW-1:0]       b_q, b_d;
   logic [WW-1:0]       w_q, w_d;
   logic                gap_q, gap_d;
   logic                ovf_q, ovf_d;
   logic                s1_vld_q, s1_vld_d;
   logic [IN_WIDTH-1:0] s1_data_q, s1_data_d;
   logic                s1_last_q, s1_last_d;

   logic [OUT_WIDTH:0]   mem_q [FIFO_DEPTH];
   logic [OUT_WIDTH:0]   mem_d [FIFO_DEPTH];
   logic [AW:0]          wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [OUT_WIDTH-1:0] hold_q, hold_d;

   logic                 empty, full, valid, pop, push_ok;
   logic [IN_WIDTH:0]    ext, sum, rq;
   logic [OUT_WIDTH-1:0] pix_val;
   logic [OUT_WIDTH:0]   head;

   // Window sequencing and stage-1 capture of the maxpool result on the last beat.
   always_comb begin
      b_d       = b_q;
      w_d       = w_q;
      gap_d     = gap_q;
      s1_vld_d  = 1'b0;
      s1_data_d = s1_data_q;
      s1_last_d = s1_last_q;
      if (i_valid) begin
         if (b_q == BW'(WIN - 1)) begin
            b_d       = '0;
            w_d       = (w_q == WW'(NWIN - 1)) ? '0 : w_q + WW'(1);
            s1_vld_d  = 1'b1;
            s1_data_d = i_mp_data;
            s1_last_d = (w_q == WW'(NWIN - 1));
         end else begin
            b_d = b_q + BW'(1);
         end
      end else if (b_q != '0) begin
         // Broken window: discard it without advancing the window count.
         gap_d = 1'b1;
         b_d   = '0;
      end
   end

   assign o_clean = i_rst || !i_valid || (b_q == '0);
   assign o_en_mp = !i_rst && i_valid && (b_q == '0);

   // ReLU, round-half-up shift and saturation; one extra bit keeps the rounding add exact.
   always_comb begin
      ext = {s1_data_q[IN_WIDTH-1], s1_data_q};
      sum = ext + Rnd;
      rq  = sum >> SHIFT;
      if (ext[IN_WIDTH]) begin
         pix_val = '0;
      end else if (rq > SatMax) begin
         pix_val = SatMax[OUT_WIDTH-1:0];
      end else begin
         pix_val = rq[OUT_WIDTH-1:0];
      end
   end

   assign empty   = (wr_ptr_q == rd_ptr_q);
   assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
   assign valid   = !i_rst && !empty;
   assign pop     = valid && pix.i_ready;
   assign push_ok = s1_vld_q && (!full || pop);
   assign head    = mem_q[rd_ptr_q[AW-1:0]];

   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      hold_d   = hold_q;
      ovf_d    = ovf_q;
      if (push_ok) begin
         mem_d[wr_ptr_q[AW-1:0]] = {s1_last_q, pix_val};
         wr_ptr_d                = wr_ptr_q + (AW+1)'(1);
      end
      if (pop) begin
         rd_ptr_d = rd_ptr_q + (AW+1)'(1);
         hold_d   = head[OUT_WIDTH-1:0];
      end
      if (s1_vld_q && full && !pop) begin
         ovf_d = 1'b1;
      end
   end

   // When empty, o_data keeps showing the most recently consumed pixel.
   assign pix.o_valid = valid;
   assign pix.o_data  = i_rst ? '0 : (empty ? hold_q : head[OUT_WIDTH-1:0]);
   assign pix.o_last  = valid && head[OUT_WIDTH];
   assign o_overflow  = ovf_q;
   assign o_gap_err   = gap_q;

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         b_q       <= '0;
         w_q       <= '0;
         gap_q     <= 1'b0;
         ovf_q     <= 1'b0;
         s1_vld_q  <= 1'b0;
         s1_data_q <= '0;
         s1_last_q <= 1'b0;
         mem_q     <= '{default: '0};
         wr_ptr_q  <= '0;
         rd_ptr_q  <= '0;
         hold_q    <= '0;
      end else begin
         b_q       <= b_d;
         w_q       <= w_d;
         gap_q     <= gap_d;
         ovf_q     <= ovf_d;
         s1_vld_q  <= s1_vld_d;
         s1_data_q <= s1_data_d;
         s1_last_q <= s1_last_d;
         mem_q     <= mem_d;
         wr_ptr_q  <= wr_ptr_d;
         rd_ptr_q  <= rd_ptr_d;
         hold_q    <= hold_d;
      end
   end

endmodule

// File: tb/tb_pool_window_ctrl.sv
// Bench for pool_window_ctrl: requant vector table, multi-cycle corner sequences and a random
// phase, all checked against a queue-based model of windows, latency and FIFO capacity.
module tb_pool_window_ctrl;

   localparam int NWIN  = 144;
   localparam int DEPTH = 4;

   logic        clk = 1'b0;
   logic        rst;
   logic        vld;
   logic [47:0] mp;
   logic        clean, en, ovf, gap;

   pool_window_ctrl_if #(.OUT_WIDTH(8)) pix ();

   pool_window_ctrl #(
      .IN_WIDTH  (48),
      .OUT_WIDTH (8),
      .POOL_SIZE (2),
      .FM_SIZE   (24),
      .SHIFT     (8),
      .FIFO_DEPTH(DEPTH)
   ) dut (
      .i_clk     (clk),
      .i_rst     (rst),
      .i_valid   (vld),
      .i_mp_data (mp),
      .o_clean   (clean),
      .o_en_mp   (en),
      .pix       (pix),
      .o_overflow(ovf),
      .o_gap_err (gap)
   );

   always #5 clk = ~clk;

   typedef struct {
      longint data;
      bit     last;
      int     due;
   } ent_t;

   typedef struct {
      longint d0, d1, d2, d3;
      longint exp;
   } vec_t;

   ent_t mq[$];
   ent_t pipe[$];
   bit   exp_ovf;
   bit   rand_rdy;
   int   tests, fails, cyc, wcount, pops, last_pops, last_pop_idx;

   // Window maximum -> pooled pixel: ReLU, divide by 256 rounding half up, clamp to 127.
   function automatic longint requant(longint m);
      longint r;
      if (m < 0) return 0;
      r = (m + 128) / 256;
      return (r > 127) ? 127 : r;
   endfunction

   task automatic check(string name, longint act, longint exp);
      tests++;
      if (act != exp) begin
         fails++;
         $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Model of the output FIFO, evaluated once per cycle away from the clock edge.
   task automatic monitor();
      ent_t e;
      if (rst) begin
         mq.delete();
         pipe.delete();
         exp_ovf = 1'b0;
      end else begin
         check("o_valid", longint'(pix.o_valid), longint'(mq.size() != 0));
         if (mq.size() != 0) begin
            check("o_data", longint'(pix.o_data), mq[0].data);
            check("o_last", longint'(pix.o_last), longint'(mq[0].last));
         end
         check("o_overflow", longint'(ovf), longint'(exp_ovf));
         if (mq.size() != 0 && pix.i_ready) begin
            pops++;
            if (mq[0].last) begin
               last_pops++;
               last_pop_idx = pops;
            end
            void'(mq.pop_front());
         end
         if (pipe.size() != 0 && pipe[0].due == cyc) begin
            e = pipe.pop_front();
            if (mq.size() == DEPTH) exp_ovf = 1'b1;
            else mq.push_back(e);
         end
      end
   endtask

   task automatic tick();
      @(negedge clk);
      monitor();
      @(posedge clk);
      #1;
      cyc++;
      if (rand_rdy) pix.i_ready = 1'($urandom % 2);
   endtask

   task automatic idle(int n);
      vld = 1'b0;
      mp  = '0;
      repeat (n) tick();
   endtask

   // One contiguous window; i_mp_data plays the maxpool's running maximum.
   task automatic win(longint a0, longint a1, longint a2, longint a3);
      longint v[4];
      longint mx;
      ent_t   e;
      v[0] = a0; v[1] = a1; v[2] = a2; v[3] = a3;
      mx = a0;
      for (int k = 0; k < 4; k++) begin
         if (v[k] > mx) mx = v[k];
         vld = 1'b1;
         mp  = mx[47:0];
         if (k == 3) begin
            e.data = requant(mx);
            e.last = (wcount == NWIN - 1);
            e.due  = cyc + 1;
            pipe.push_back(e);
            wcount = (wcount + 1) % NWIN;
         end
         #1;
         check("o_clean", longint'(clean), longint'(k == 0));
         check("o_en_mp", longint'(en), longint'(k == 0));
         tick();
      end
   endtask

   task automatic do_reset();
      rst = 1'b1;
      vld = 1'b1;
      mp  = '0;
      tick();
      check("rst o_clean", longint'(clean), 1);
      check("rst o_en_mp", longint'(en), 0);
      check("rst o_valid", longint'(pix.o_valid), 0);
      check("rst o_data", longint'(pix.o_data), 0);
      check("rst o_last", longint'(pix.o_last), 0);
      tick();
      rst    = 1'b0;
      vld    = 1'b0;
      wcount = 0;
      check("rst o_overflow", longint'(ovf), 0);
      check("rst o_gap_err", longint'(gap), 0);
   endtask

   vec_t tbl[8];
   int   p0;

   initial begin
      tbl[0] = '{d0: 100,     d1: 300,   d2: -50, d3: 600, exp: 2};
      tbl[1] = '{d0: -5,      d1: -5,    d2: -5,  d3: -5,  exp: 0};
      tbl[2] = '{d0: 384,     d1: 0,     d2: 0,   d3: 0,   exp: 2};
      tbl[3] = '{d0: 65535,   d1: 1,     d2: 2,   d3: 3,   exp: 127};
      tbl[4] = '{d0: 383,     d1: -1,    d2: 200, d3: 100, exp: 1};
      tbl[5] = '{d0: 127,     d1: 0,     d2: 0,   d3: 0,   exp: 0};
      tbl[6] = '{d0: -100000, d1: 32640, d2: 5,   d3: 5,   exp: 127};
      tbl[7] = '{d0: 640,     d1: 1,     d2: 1,   d3: 32639, exp: 127};

      tests = 0; fails = 0; cyc = 0; wcount = 0; pops = 0; last_pops = 0; last_pop_idx = 0;
      exp_ovf = 1'b0; rand_rdy = 1'b0;
      rst = 1'b1; vld = 1'b0; mp = '0; pix.i_ready = 1'b1;
      do_reset();

      // Requant table; o_valid must rise exactly two cycles after the last beat.
      foreach (tbl[i]) begin
         win(tbl[i].d0, tbl[i].d1, tbl[i].d2, tbl[i].d3);
         vld = 1'b0;
         check("latency t+1 o_valid", longint'(pix.o_valid), 0);
         tick();
         check("latency t+2 o_valid", longint'(pix.o_valid), 1);
         check($sformatf("vec%0d o_data", i), longint'(pix.o_data), tbl[i].exp);
         idle(3);
      end

      // Full feature map plus one window, consumer always ready.
      do_reset();
      p0 = pops;
      last_pops = 0;
      for (int i = 0; i < NWIN + 1; i++) begin
         win(longint'($urandom_range(0, 40000)), longint'($urandom_range(0, 40000)),
             longint'($urandom_range(0, 40000)), longint'($urandom_range(0, 40000)));
      end
      idle(4);
      check("stream outputs", pops - p0, NWIN + 1);
      check("stream last count", last_pops, 1);
      check("stream last index", last_pop_idx - p0, NWIN);

      // Stalled consumer: four pixels held, the rest dropped, then drained in order.
      do_reset();
      pix.i_ready = 1'b0;
      for (int k = 1; k <= 6; k++) win(256 * k, 0, 0, 0);
      idle(3);
      check("ovf o_overflow", longint'(ovf), 1);
      check("ovf o_valid", longint'(pix.o_valid), 1);
      check("ovf head", longint'(pix.o_data), 1);
      p0 = pops;
      pix.i_ready = 1'b1;
      idle(6);
      check("ovf drained", pops - p0, 4);
      check("ovf empty", longint'(pix.o_valid), 0);

      // Window broken after beat 1.
      do_reset();
      p0 = pops;
      vld = 1'b1; mp = 48'd10;  tick();
      vld = 1'b1; mp = 48'd20;  tick();
      vld = 1'b0; mp = '0;
      #1;
      check("gap o_clean", longint'(clean), 1);
      check("gap o_en_mp", longint'(en), 0);
      tick();
      check("gap o_gap_err", longint'(gap), 1);
      idle(3);
      check("gap no output", pops - p0, 0);
      win(1000, 3, 2, 1);
      idle(3);
      check("gap next window", pops - p0, 1);

      // Reset mid-window with a pixel still queued.
      pix.i_ready = 1'b0;
      win(700, 0, 0, 0);
      idle(3);
      check("pre-rst o_valid", longint'(pix.o_valid), 1);
      vld = 1'b1; mp = 48'd5000; tick();
      vld = 1'b1; mp = 48'd5000; tick();
      vld = 1'b1; mp = 48'd5000; tick();
      do_reset();
      check("post-rst o_valid", longint'(pix.o_valid), 0);
      check("post-rst o_gap_err", longint'(gap), 0);
      pix.i_ready = 1'b1;
      win(50, 1000, 900, -3);
      vld = 1'b0;
      tick();
      check("post-rst o_valid t+2", longint'(pix.o_valid), 1);
      check("post-rst o_data", longint'(pix.o_data), 4);
      idle(3);

      // Random windows, idle gaps and consumer back-pressure.
      rand_rdy = 1'b1;
      for (int i = 0; i < 60; i++) begin
         win(longint'($urandom_range(0, 80000)) - 5000, longint'($urandom_range(0, 80000)) - 5000,
             longint'($urandom_range(0, 80000)) - 5000, longint'($urandom_range(0, 80000)) - 5000);
         idle(int'($urandom_range(0, 2)));
      end
      rand_rdy = 1'b0;
      pix.i_ready = 1'b1;
      idle(8);
      check("final empty", longint'(pix.o_valid), 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
